// File: rtl/alu_issue.sv
// Operand issue stage for the alu block: buffers commands in a small FIFO, issues
// them one per cycle with an en strobe, and returns each ALU result with its opcode.
module alu_issue #(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_a,
  input  logic [31:0]                in_b,
  input  logic [1:0]                 in_op,
  input  logic                       hold,
  output logic [31:0]                alu_a,
  output logic [31:0]                alu_b,
  output logic [1:0]                 alu_op,
  output logic                       alu_en,
  input  logic [31:0]                alu_result,
  output logic                       out_valid,
  output logic [31:0]                out_result,
  output logic [1:0]                 out_op,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  // Entry layout: {op, a, b}
  logic [65:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [AW:0]   count_next;

  logic [31:0]   alu_a_reg;
  logic [31:0]   alu_b_reg;
  logic [1:0]    alu_op_reg;
  logic          alu_en_reg;

  logic          trk_v_reg  [ALU_LAT+1];
  logic [1:0]    trk_op_reg [ALU_LAT+1];

  logic          out_valid_reg;
  logic [31:0]   out_result_reg;
  logic [1:0]    out_op_reg;

  logic          push;
  logic          pop;
  logic [65:0]   head;

  // Readiness comes from the registered count only, so a pop never frees a slot
  // for a push in the same cycle.
  assign in_ready = (count_reg < DEPTH_C);
  assign push     = in_valid & in_ready;
  assign pop      = (count_reg != '0) & ~hold;
  assign head     = mem[rd_ptr_reg];

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {in_op, in_a, in_b};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      alu_a_reg  <= '0;
      alu_b_reg  <= '0;
      alu_op_reg <= '0;
      alu_en_reg <= 1'b0;
    end else begin
      count_reg  <= count_next;
      alu_en_reg <= pop;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
        alu_op_reg <= head[65:64];
        alu_a_reg  <= head[63:32];
        alu_b_reg  <= head[31:0];
      end
    end
  end

  // Stage k holds the command issued k edges ago; the last stage lines up with
  // the edge after the ALU has registered its result.
  always_ff @(posedge clk) begin
    if (rst) begin
      trk_v_reg[0]  <= 1'b0;
      trk_op_reg[0] <= '0;
    end else begin
      trk_v_reg[0]  <= pop;
      trk_op_reg[0] <= pop ? head[65:64] : trk_op_reg[0];
    end
  end

  generate
    for (genvar gi = 1; gi <= ALU_LAT; gi++) begin : g_trk
      always_ff @(posedge clk) begin
        if (rst) begin
          trk_v_reg[gi]  <= 1'b0;
          trk_op_reg[gi] <= '0;
        end else begin
          trk_v_reg[gi]  <= trk_v_reg[gi-1];
          trk_op_reg[gi] <= trk_op_reg[gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg  <= 1'b0;
      out_result_reg <= '0;
      out_op_reg     <= '0;
    end else begin
      out_valid_reg <= trk_v_reg[ALU_LAT];
      if (trk_v_reg[ALU_LAT]) begin
        out_result_reg <= alu_result;
        out_op_reg     <= trk_op_reg[ALU_LAT];
      end
    end
  end

  assign alu_a      = alu_a_reg;
  assign alu_b      = alu_b_reg;
  assign alu_op     = alu_op_reg;
  assign alu_en     = alu_en_reg;
  assign out_valid  = out_valid_reg;
  assign out_result = out_result_reg;
  assign out_op     = out_op_reg;
  assign count      = count_reg;

endmodule

// File: tb/tb_alu_issue.sv
// Randomized scoreboard bench for alu_issue with a registered one-cycle ALU stub.
module tb_alu_issue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [1:0]  in_op = '0;
  logic        hold = 1'b0;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [1:0]  alu_op;
  logic        alu_en;
  logic [31:0] alu_result = '0;
  logic        out_valid;
  logic [31:0] out_result;
  logic [1:0]  out_op;
  logic [2:0]  count;

  alu_issue #(.DEPTH(DEPTH), .ALU_LAT(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .hold(hold),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_en(alu_en),
    .alu_result(alu_result), .out_valid(out_valid), .out_result(out_result),
    .out_op(out_op), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(logic [31:0] a, logic [31:0] b, logic [1:0] op);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a ^ b;
      default: return a & b;
    endcase
  endfunction

  // ALU stub: registers the result on the edge after en, then holds it
  always @(posedge clk) if (alu_en) alu_result <= alu_fn(alu_a, alu_b, alu_op);

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] res;
    int          due;
  } cmd_t;

  cmd_t fifo_q[$];
  cmd_t exp_q[$];
  cmd_t exp_cmd;
  logic exp_en = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: FIFO of commands, issue when non-empty and not held,
  // result due two edges after issue; reset discards everything.
  always @(posedge clk) begin
    bit   do_pop;
    bit   do_push;
    cmd_t c;
    cyc++;
    if (rst) begin
      fifo_q.delete();
      exp_q.delete();
      exp_en = 1'b0;
    end else begin
      do_pop  = (fifo_q.size() > 0) && !hold;
      do_push = in_valid && (fifo_q.size() < DEPTH);
      exp_en  = do_pop;
      if (do_pop) begin
        c = fifo_q.pop_front();
        c.due = cyc + 2;
        c.res = alu_fn(c.a, c.b, c.op);
        exp_cmd = c;
        exp_q.push_back(c);
      end
      if (do_push) begin
        c.a = in_a; c.b = in_b; c.op = in_op; c.res = '0; c.due = 0;
        fifo_q.push_back(c);
      end
    end
  end

  always @(negedge clk) begin
    cmd_t e;
    if (cyc > 0) begin
      chk("count", 32'(count), 32'(fifo_q.size()));
      chk("in_ready", 32'(in_ready), 32'(fifo_q.size() < DEPTH));
      chk("alu_en", 32'(alu_en), 32'(exp_en));
      if (exp_en) begin
        chk("alu_a", alu_a, exp_cmd.a);
        chk("alu_b", alu_b, exp_cmd.b);
        chk("alu_op", 32'(alu_op), 32'(exp_cmd.op));
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("out_result", out_result, e.res);
          chk("out_op", 32'(out_op), 32'(e.op));
          chk("out_latency", 32'(cyc), 32'(e.due));
          $display("result a=%0h b=%0h op=%0d -> %0h", e.a, e.b, e.op, out_result);
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        chk("missing_out_valid", 32'(out_valid), 32'd1);
      end
    end
  end

  task automatic drive(bit v, bit h, logic [31:0] a, logic [31:0] b, logic [1:0] op);
    @(negedge clk);
    in_valid = v; hold = h; in_a = a; in_b = b; in_op = op;
  endtask

  task automatic idle(int n, bit h);
    repeat (n) drive(1'b0, h, $urandom, $urandom, 2'($urandom_range(0, 3)));
  endtask

  initial begin
    // Reset with in_valid asserted
    rst = 1'b1; in_valid = 1'b1; in_a = 32'h1234; in_b = 32'h5678;
    repeat (2) begin
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_result", out_result, 32'd0);
      chk("rst_out_op", 32'(out_op), 32'd0);
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_alu_b", alu_b, 32'd0);
      chk("rst_alu_op", 32'(alu_op), 32'd0);
    end
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Single command
    drive(1'b1, 1'b0, 32'd19260817, 32'd99999999, 2'd0);
    idle(5, 1'b0);

    // Back-to-back
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, $urandom, $urandom, 2'(i % 2));
    idle(6, 1'b0);

    // Fill while held, push+pop at full, then drain
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 32'(100 + i), 32'(i), 2'(i));
    drive(1'b1, 1'b0, 32'hdead, 32'hbeef, 2'd3);
    drive(1'b1, 1'b1, 32'hcafe, 32'hf00d, 2'd2);
    idle(8, 1'b0);

    // Random traffic with random hold, forcing pointer wrap
    for (int i = 0; i < 40; i++)
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom, $urandom,
            2'($urandom_range(0, 3)));
    idle(20, 1'b0);
    chk("drained_exp", 32'(exp_q.size()), 32'd0);

    // Reset one edge after alu_en, with more entries still queued
    drive(1'b1, 1'b1, 32'd100, 32'd1, 2'd0);
    drive(1'b1, 1'b1, 32'd200, 32'd2, 2'd1);
    drive(1'b1, 1'b1, 32'd300, 32'd3, 2'd0);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 2'd0);
    @(negedge clk);
    chk("pre_rst_alu_en", 32'(alu_en), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(6, 1'b0);
    chk("post_mid_rst_count", 32'(count), 32'd0);

    // Block still works after reset
    drive(1'b1, 1'b0, 32'd7, 32'd5, 2'd1);
    idle(5, 1'b0);
    chk("final_exp_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
